app_tx_udp_frame_gen: RTL and testbench

// - Descriptor-driven transmit frame generator for the app block's sync TX path.
// - Builds one Ethernet/[802.1Q]/IPv4/UDP frame per descriptor and emits it on a 512-bit AXI-Stream master.
// - Counterpart of the app block's sync RX ingress; produces frames that the RX parser accepts.

---
 rtl/app_tx_udp_frame_gen_if.sv | 40 ++++
 rtl/app_tx_udp_frame_gen.sv | 166 ++++++++++++++++
 tb/tb_app_tx_udp_frame_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/app_tx_udp_frame_gen_if.sv
// Descriptor + AXI-Stream bundle for the TX UDP frame generator.
// The generator is the master: it consumes descriptors and sources the stream.
interface app_tx_udp_frame_gen_if #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64
);
  logic                       s_desc_valid;
  logic                       s_desc_ready;
  logic [47:0]                s_desc_dst_mac;
  logic [47:0]                s_desc_src_mac;
  logic [15:0]                s_desc_vlan_tci;
  logic [31:0]                s_desc_src_ip;
  logic [31:0]                s_desc_dst_ip;
  logic [15:0]                s_desc_src_port;
  logic [15:0]                s_desc_dst_port;
  logic [15:0]                s_desc_payload_len;
  logic [7:0]                 s_desc_seed;
  logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic                       m_axis_tlast;
  logic                       m_axis_tuser;

  modport master (
    input  s_desc_valid, s_desc_dst_mac, s_desc_src_mac, s_desc_vlan_tci,
           s_desc_src_ip, s_desc_dst_ip, s_desc_src_port, s_desc_dst_port,
           s_desc_payload_len, s_desc_seed, m_axis_tready,
    output s_desc_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
           m_axis_tlast, m_axis_tuser
  );

  modport slave (
    output s_desc_valid, s_desc_dst_mac, s_desc_src_mac, s_desc_vlan_tci,
           s_desc_src_ip, s_desc_dst_ip, s_desc_src_port, s_desc_dst_port,
           s_desc_payload_len, s_desc_seed, m_axis_tready,
    input  s_desc_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
           m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/app_tx_udp_frame_gen.sv
// Descriptor-driven Ethernet/IPv4/UDP frame generator on a 512-bit AXI-Stream.
// Define APP_TX_VLAN_EN to insert an 802.1Q tag after the source MAC.
module app_tx_udp_frame_gen #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int MAX_PAYLOAD     = 1472
) (
  input  logic                    clk,
  input  logic                    rst_n,
  app_tx_udp_frame_gen_if.master  bus,
  output logic                    busy,
  output logic [31:0]             stat_tx_frames
);

`ifdef APP_TX_VLAN_EN
  localparam int HDR_BYTES = 46;
  localparam int PMIN      = 14;
`else
  localparam int HDR_BYTES = 42;
  localparam int PMIN      = 18;
`endif
  localparam logic [11:0] HDR_LEN  = 12'(HDR_BYTES);
  localparam logic [7:0]  HDR_LEN8 = 8'(HDR_BYTES);
  localparam logic [15:0] PMIN_LEN = 16'(PMIN);
  localparam logic [15:0] PMAX_LEN = 16'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, CSUM, HDR, PAY} state_t;
  state_t state, state_nxt;

  logic [47:0] dst_mac, src_mac;
`ifdef APP_TX_VLAN_EN
  logic [15:0] vlan_tci;
`endif
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, pay_len;
  logic [7:0]  seed;
  logic [15:0] ip_csum, ip_id;
  logic [4:0]  beat_idx;

  logic        desc_fire, beat_fire, load_beat;
  logic [15:0] len_clamped, ip_len, udp_len, csum_calc;
  logic [11:0] frame_len, beat_base, rem, byte_idx;
  logic [19:0] csum_sum;
  logic [16:0] csum_f1, csum_f2;
  logic [7:0]  pay_base;
  logic                       beat_last;
  logic [AXIS_KEEP_WIDTH-1:0] beat_keep;
  logic [AXIS_DATA_WIDTH-1:0] beat_data, hdr_pad;

  assign desc_fire = bus.s_desc_valid && bus.s_desc_ready;
  assign beat_fire = bus.m_axis_tvalid && bus.m_axis_tready;
  // Beat 0 is loaded the first HDR cycle; later beats replace each accepted non-last beat.
  assign load_beat = ((state == HDR) && !bus.m_axis_tvalid) || (beat_fire && !bus.m_axis_tlast);
  assign busy           = (state != IDLE);
  assign bus.m_axis_tuser = 1'b0;

  assign len_clamped = (bus.s_desc_payload_len < PMIN_LEN) ? PMIN_LEN :
                       (bus.s_desc_payload_len > PMAX_LEN) ? PMAX_LEN : bus.s_desc_payload_len;
  assign ip_len    = pay_len + 16'd28;
  assign udp_len   = pay_len + 16'd8;
  assign frame_len = HDR_LEN + pay_len[11:0];

  // Ten 16-bit header words fit in 20 bits, so two end-around folds always suffice.
  assign csum_sum = 20'h04500 + 20'(ip_len) + 20'(ip_id) + 20'h04000 + 20'h04011
                  + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
                  + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
  assign csum_f1   = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
  assign csum_f2   = 17'(csum_f1[15:0]) + 17'(csum_f1[16]);
  assign csum_calc = ~csum_f2[15:0];

  // Header in wire order, left-aligned so wire byte k sits at slot (63-k).
`ifdef APP_TX_VLAN_EN
  assign hdr_pad = {dst_mac, src_mac, 16'h8100, vlan_tci, 16'h0800,
                    16'h4500, ip_len, ip_id, 16'h4000, 16'h4011, ip_csum, src_ip, dst_ip,
                    src_port, dst_port, udp_len, 16'h0000,
                    {(AXIS_KEEP_WIDTH-HDR_BYTES)*8{1'b0}}};
`else
  assign hdr_pad = {dst_mac, src_mac, 16'h0800,
                    16'h4500, ip_len, ip_id, 16'h4000, 16'h4011, ip_csum, src_ip, dst_ip,
                    src_port, dst_port, udp_len, 16'h0000,
                    {(AXIS_KEEP_WIDTH-HDR_BYTES)*8{1'b0}}};
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    beat_base = {1'b0, beat_idx, 6'b0};
    rem       = frame_len - beat_base;
    beat_last = (rem <= 12'd64);
    beat_keep = (rem >= 12'd64) ? '1
              : (AXIS_KEEP_WIDTH'(1) << rem[5:0]) - AXIS_KEEP_WIDTH'(1);
    pay_base  = seed - HDR_LEN8 + {beat_idx[1:0], 6'b0};
    beat_data = '0;
    byte_idx  = '0;
    for (int j = 0; j < AXIS_KEEP_WIDTH; j++) begin
      byte_idx = beat_base + 12'(j);
      if (byte_idx < HDR_LEN)
        beat_data[j*8 +: 8] = hdr_pad[(AXIS_KEEP_WIDTH-1-j)*8 +: 8];
      else if (byte_idx < frame_len)
        beat_data[j*8 +: 8] = pay_base + 8'(j);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (desc_fire) state_nxt = CSUM;
      CSUM: state_nxt = HDR;
      HDR:  if (beat_fire) state_nxt = bus.m_axis_tlast ? IDLE : PAY;
      PAY:  if (beat_fire && bus.m_axis_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: descriptor fields and checksum are always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (desc_fire) begin
      dst_mac  <= bus.s_desc_dst_mac;
      src_mac  <= bus.s_desc_src_mac;
`ifdef APP_TX_VLAN_EN
      vlan_tci <= bus.s_desc_vlan_tci;
`endif
      src_ip   <= bus.s_desc_src_ip;
      dst_ip   <= bus.s_desc_dst_ip;
      src_port <= bus.s_desc_src_port;
      dst_port <= bus.s_desc_dst_port;
      pay_len  <= len_clamped;
      seed     <= bus.s_desc_seed;
    end
    if (state == CSUM) ip_csum <= csum_calc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s_desc_ready  <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tkeep  <= '0;
      bus.m_axis_tdata  <= '0;
      beat_idx          <= '0;
      ip_id             <= '0;
      stat_tx_frames    <= '0;
    end else begin
      bus.s_desc_ready <= (state_nxt == IDLE);
      if (desc_fire) beat_idx <= '0;
      if (load_beat) begin
        bus.m_axis_tdata  <= beat_data;
        bus.m_axis_tkeep  <= beat_keep;
        bus.m_axis_tlast  <= beat_last;
        bus.m_axis_tvalid <= 1'b1;
        beat_idx          <= beat_idx + 5'd1;
      end else if (beat_fire && bus.m_axis_tlast) begin
        bus.m_axis_tvalid <= 1'b0;
        bus.m_axis_tlast  <= 1'b0;
        ip_id             <= ip_id + 16'd1;
        stat_tx_frames    <= stat_tx_frames + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_app_tx_udp_frame_gen.sv
// Self-checking bench for app_tx_udp_frame_gen: directed cases plus random descriptors
// compared byte-for-byte against a frame model built from the header/payload rules.
module tb_app_tx_udp_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [31:0] stat_tx_frames;

  always #5 clk = ~clk;

  app_tx_udp_frame_gen_if bus ();

  app_tx_udp_frame_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .busy           (busy),
    .stat_tx_frames (stat_tx_frames)
  );

`ifdef APP_TX_VLAN_EN
  localparam int          H          = 46;
  localparam int          PMIN       = 14;
  localparam int          IPO        = 18;
  localparam logic [15:0] ETYPE_1213 = 16'h8100;
  localparam logic [7:0]  BYTE63_P18 = 8'h11;
  localparam logic [63:0] KEEP_P18   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] KEEP_P100  = 64'h3_FFFF;
  localparam logic [63:0] KEEP_P2000 = 64'h3FFF_FFFF_FFFF;
`else
  localparam int          H          = 42;
  localparam int          PMIN       = 18;
  localparam int          IPO        = 14;
  localparam logic [15:0] ETYPE_1213 = 16'h0800;
  localparam logic [7:0]  BYTE63_P18 = 8'h00;
  localparam logic [63:0] KEEP_P18   = 64'h0FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] KEEP_P100  = 64'h3FFF;
  localparam logic [63:0] KEEP_P2000 = 64'h3FF_FFFF_FFFF;
`endif

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] tci;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] plen;
    logic [7:0]  seed;
  } desc_t;

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] exp_ip_id = '0;
  int          exp_frames = 0;

  logic [7:0]   model[$];
  logic [511:0] rx_data[$];
  logic [63:0]  rx_keep[$];
  logic         rx_last[$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    d.dst_mac = {$urandom, $urandom};
    d.src_mac = {$urandom, $urandom};
    d.tci     = 16'($urandom);
    d.sip     = $urandom;
    d.dip     = $urandom;
    d.sport   = 16'($urandom);
    d.dport   = 16'($urandom);
    d.plen    = 16'($urandom_range(0, 1600));
    d.seed    = 8'($urandom);
    return d;
  endfunction

  function automatic void put16(input logic [15:0] v);
    model.push_back(v[15:8]);
    model.push_back(v[7:0]);
  endfunction

  // Reference frame: header fields in wire order, then the counting payload.
  task automatic build_model(input desc_t d, input logic [15:0] id);
    int          p;
    int unsigned s;
    logic [15:0] cs;
    p = int'(d.plen);
    if (p < PMIN) p = PMIN;
    if (p > 1472) p = 1472;
    model.delete();
    for (int i = 5; i >= 0; i--) model.push_back(d.dst_mac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) model.push_back(d.src_mac[i*8 +: 8]);
`ifdef APP_TX_VLAN_EN
    put16(16'h8100);
    put16(d.tci);
`endif
    put16(16'h0800);
    put16(16'h4500);
    put16(16'(28 + p));
    put16(id);
    put16(16'h4000);
    put16(16'h4011);
    put16(16'h0000);
    put16(d.sip[31:16]); put16(d.sip[15:0]);
    put16(d.dip[31:16]); put16(d.dip[15:0]);
    put16(d.sport);
    put16(d.dport);
    put16(16'(8 + p));
    put16(16'h0000);
    for (int k = 0; k < p; k++) model.push_back(8'((int'(d.seed) + k) % 256));
    s = 0;
    for (int w = 0; w < 10; w++) s += {16'h0, model[IPO+2*w], model[IPO+2*w+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    model[IPO+10] = cs[15:8];
    model[IPO+11] = cs[7:0];
  endtask

  function automatic logic [7:0] rx_byte(input int i);
    logic [511:0] w;
    w = rx_data[i/64];
    return w[(i%64)*8 +: 8];
  endfunction

  task automatic send(input desc_t d);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.s_desc_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("desc_ready_wait", bus.s_desc_ready, 1'b1);
    bus.s_desc_dst_mac     = d.dst_mac;
    bus.s_desc_src_mac     = d.src_mac;
    bus.s_desc_vlan_tci    = d.tci;
    bus.s_desc_src_ip      = d.sip;
    bus.s_desc_dst_ip      = d.dip;
    bus.s_desc_src_port    = d.sport;
    bus.s_desc_dst_port    = d.dport;
    bus.s_desc_payload_len = d.plen;
    bus.s_desc_seed        = d.seed;
    bus.s_desc_valid       = 1'b1;
    @(posedge clk);
    #1;
    // Scrambled fields must be ignored once the descriptor is taken.
    bus.s_desc_valid       = 1'b0;
    bus.s_desc_dst_mac     = {$urandom, $urandom};
    bus.s_desc_src_ip      = $urandom;
    bus.s_desc_payload_len = 16'($urandom);
    bus.s_desc_seed        = 8'($urandom);
  endtask

  // mode 0: tready always 1; 1: toggles 1-0-1; 2: random
  task automatic collect(input int mode, output int lat);
    logic         held, done;
    logic [511:0] hd;
    logic [63:0]  hk;
    logic         hl;
    held = 1'b0; done = 1'b0; hd = '0; hk = '0; hl = 1'b0;
    lat = 0;
    rx_data.delete(); rx_keep.delete(); rx_last.delete();
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      case (mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = (cyc % 2 == 0);
        default: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
      if (bus.m_axis_tvalid) begin
        if (held) begin
          check("hold_tdata", bus.m_axis_tdata, hd);
          check("hold_tkeep", bus.m_axis_tkeep, hk);
          check("hold_tlast", bus.m_axis_tlast, hl);
        end
        if (bus.m_axis_tready) begin
          rx_data.push_back(bus.m_axis_tdata);
          rx_keep.push_back(bus.m_axis_tkeep);
          rx_last.push_back(bus.m_axis_tlast);
          if (rx_data.size() == 1) check("tuser", bus.m_axis_tuser, 1'b0);
          done = bus.m_axis_tlast;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = bus.m_axis_tdata; hk = bus.m_axis_tkeep; hl = bus.m_axis_tlast;
        end
      end else if (held || rx_data.size() > 0) begin
        check("tvalid_midframe", bus.m_axis_tvalid, 1'b1);
      end else begin
        lat++;
      end
    end
    check("frame_done", done, 1'b1);
  endtask

  task automatic compare_frame();
    int           len, nb;
    logic [511:0] ed;
    logic [63:0]  ek;
    int unsigned  s;
    len = model.size();
    nb  = (len + 63) / 64;
    check("beat_count", rx_data.size(), nb);
    for (int b = 0; b < nb && b < rx_data.size(); b++) begin
      ed = '0; ek = '0;
      for (int j = 0; j < 64; j++) begin
        if (b*64 + j < len) begin
          ed[j*8 +: 8] = model[b*64 + j];
          ek[j] = 1'b1;
        end
      end
      check($sformatf("beat%0d_tdata", b), rx_data[b], ed);
      check($sformatf("beat%0d_tkeep", b), rx_keep[b], ek);
      check($sformatf("beat%0d_tlast", b), rx_last[b], (b == nb - 1));
    end
    if (rx_data.size() > 0) begin
      s = 0;
      for (int w = 0; w < 10; w++) s += {16'h0, rx_byte(IPO+2*w), rx_byte(IPO+2*w+1)};
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      check("ip_csum_verify", s, 32'hFFFF);
      check("ip_id", {rx_byte(IPO+4), rx_byte(IPO+5)}, exp_ip_id);
    end
  endtask

  task automatic run_frame(input desc_t d, input int mode);
    int lat;
    build_model(d, exp_ip_id);
    send(d);
    collect(mode, lat);
    check("latency", lat, 2);
    compare_frame();
    exp_ip_id++;
    exp_frames++;
    @(negedge clk);
    check("ready_after_tlast", bus.s_desc_ready, 1'b1);
    check("busy_after_tlast", busy, 1'b0);
    check("stat_tx_frames", stat_tx_frames, exp_frames);
  endtask

  initial begin
    desc_t d;
    bit    got;
    bus.s_desc_valid       = 1'b0;
    bus.s_desc_dst_mac     = '0;
    bus.s_desc_src_mac     = '0;
    bus.s_desc_vlan_tci    = '0;
    bus.s_desc_src_ip      = '0;
    bus.s_desc_dst_ip      = '0;
    bus.s_desc_src_port    = '0;
    bus.s_desc_dst_port    = '0;
    bus.s_desc_payload_len = '0;
    bus.s_desc_seed        = '0;
    bus.m_axis_tready      = 1'b0;

    // Reset values
    #12;
    check("rst_ready", bus.s_desc_ready, 1'b0);
    check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
    check("rst_tlast", bus.m_axis_tlast, 1'b0);
    check("rst_tkeep", bus.m_axis_tkeep, 64'h0);
    check("rst_tdata", bus.m_axis_tdata, 512'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_stat", stat_tx_frames, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.s_desc_ready, 1'b1);

    // Minimum-size frame, seed 0
    d = rand_desc();
    d.plen = 16'd18;
    d.seed = 8'h00;
    run_frame(d, 0);
    check("p18_bytes_12_13", {rx_byte(12), rx_byte(13)}, ETYPE_1213);
    check("p18_ip_len", {rx_byte(IPO+2), rx_byte(IPO+3)}, 16'h002E);
    check("p18_udp_len", {rx_byte(IPO+24), rx_byte(IPO+25)}, 16'h001A);
    check("p18_byte63", rx_byte(63), BYTE63_P18);
    check("p18_tkeep", rx_keep[0], KEEP_P18);

    // Back-to-back: second frame carries ip_id 1, stat becomes 2
    d = rand_desc();
    d.plen = 16'd100;
    run_frame(d, 0);
    check("p100_beats", rx_data.size(), 3);
    check("p100_last_tkeep", rx_keep[2], KEEP_P100);
    check("b2b_stat", stat_tx_frames, 32'd2);

    // Undersize and oversize clamping
    d = rand_desc();
    d.plen = 16'd5;
    run_frame(d, 2);
    check("p5_ip_len", {rx_byte(IPO+2), rx_byte(IPO+3)}, 16'(28 + PMIN));
    check("p5_beats", rx_data.size(), 1);
    d = rand_desc();
    d.plen = 16'd2000;
    run_frame(d, 0);
    check("p2000_beats", rx_data.size(), 24);
    check("p2000_last_tkeep", rx_keep[23], KEEP_P2000);
    check("p2000_ip_len", {rx_byte(IPO+2), rx_byte(IPO+3)}, 16'h05DC);

    // Backpressure toggling on a 3-beat frame
    d = rand_desc();
    d.plen = 16'd100;
    run_frame(d, 1);

    // Random descriptors with random backpressure
    for (int i = 0; i < 6; i++) begin
      d = rand_desc();
      run_frame(d, 2);
    end

    // Reset while beat 1 of 3 is on the bus
    d = rand_desc();
    d.plen = 16'd100;
    send(d);
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      bus.m_axis_tready = 1'b1;
      got = bus.m_axis_tvalid;
    end
    @(negedge clk);
    check("beat1_valid_before_rst", bus.m_axis_tvalid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", bus.m_axis_tvalid, 1'b0);
    check("midrst_tlast", bus.m_axis_tlast, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_stat", stat_tx_frames, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ip_id  = '0;
    exp_frames = 0;
    d = rand_desc();
    run_frame(d, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
